// File: rtl/image_stream_loader.sv
// Byte-stream front end for the downscaler: parses a 7-byte header, writes pixels
// into the frame RAM input region, then hands the frame to the control unit.
module image_stream_loader #(
    parameter int unsigned         ADDR_W     = 19,
    parameter logic [ADDR_W-1:0]   IN_BASE    = '0,
    parameter int unsigned         MAX_PIXELS = 262144
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_out,
    output logic              mem_sel,
    output logic [15:0]       cfg_width,
    output logic [15:0]       cfg_height,
    output logic [15:0]       cfg_scale,
    output logic [7:0]        cfg_mode,
    output logic              start_proc_pulse,
    input  logic              cu_busy,
    output logic              load_done,
    output logic              err_size
);

    typedef enum logic [2:0] {
        S_HDR,
        S_CHECK,
        S_PIX,
        S_FLUSH,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ERROR
    } state_t;

    state_t            state_q;
    logic [2:0]        hdr_cnt_q;
    logic [15:0]       sh_w_q, sh_h_q, sh_scale_q;
    logic [7:0]        sh_mode_q;
    logic [15:0]       cfg_w_q, cfg_h_q, cfg_scale_q;
    logic [7:0]        cfg_mode_q;
    logic [31:0]       npix_q;
    logic [18:0]       pix_cnt_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;
    logic              start_q, done_q, err_q;

    logic [31:0] npix_d;
    logic        last_pix;

    assign npix_d   = 32'(sh_w_q) * 32'(sh_h_q);
    assign last_pix = (32'(pix_cnt_q) + 32'd1) == npix_q;

    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            state_q     <= S_HDR;
            hdr_cnt_q   <= '0;
            sh_w_q      <= '0;
            sh_h_q      <= '0;
            sh_scale_q  <= '0;
            sh_mode_q   <= '0;
            cfg_w_q     <= '0;
            cfg_h_q     <= '0;
            cfg_scale_q <= '0;
            cfg_mode_q  <= '0;
            npix_q      <= '0;
            pix_cnt_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_HDR: begin
                    if (s_valid) begin
                        case (hdr_cnt_q)
                            3'd0:    sh_w_q[7:0]      <= s_data;
                            3'd1:    sh_w_q[15:8]     <= s_data;
                            3'd2:    sh_h_q[7:0]      <= s_data;
                            3'd3:    sh_h_q[15:8]     <= s_data;
                            3'd4:    sh_scale_q[7:0]  <= s_data;
                            3'd5:    sh_scale_q[15:8] <= s_data;
                            default: sh_mode_q        <= s_data;
                        endcase
                        if (hdr_cnt_q == 3'd6) begin
                            hdr_cnt_q <= '0;
                            state_q   <= S_CHECK;
                        end else begin
                            hdr_cnt_q <= hdr_cnt_q + 3'd1;
                        end
                    end
                end
                S_CHECK: begin
                    // cfg outputs only change on a header that passes the size check
                    if (sh_w_q == '0 || sh_h_q == '0 || npix_d > MAX_PIXELS) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        cfg_w_q     <= sh_w_q;
                        cfg_h_q     <= sh_h_q;
                        cfg_scale_q <= sh_scale_q;
                        cfg_mode_q  <= sh_mode_q;
                        npix_q      <= npix_d;
                        pix_cnt_q   <= '0;
                        state_q     <= S_PIX;
                    end
                end
                S_PIX: begin
                    if (s_valid) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= IN_BASE + ADDR_W'(pix_cnt_q);
                        mem_data_q <= s_data;
                        pix_cnt_q  <= pix_cnt_q + 19'd1;
                        if (last_pix) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    start_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_START;
                end
                S_START: state_q <= S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (cu_busy) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!cu_busy) begin
                        state_q <= S_HDR;
                    end
                end
                S_ERROR: state_q <= S_ERROR;
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign s_ready          = (state_q == S_HDR) || (state_q == S_PIX);
    assign mem_sel          = (state_q == S_HDR) || (state_q == S_CHECK) ||
                              (state_q == S_PIX) || (state_q == S_FLUSH);
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_data_out     = mem_data_q;
    assign cfg_width        = cfg_w_q;
    assign cfg_height       = cfg_h_q;
    assign cfg_scale        = cfg_scale_q;
    assign cfg_mode         = cfg_mode_q;
    assign start_proc_pulse = start_q;
    assign load_done        = done_q;
    assign err_size         = err_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader: expected RAM writes come from a frame
// model queue; a per-cycle compare process checks writes, pulses and bus ownership.
module tb_image_stream_loader;

    localparam int unsigned       ADDR_W  = 19;
    localparam logic [ADDR_W-1:0] IN_BASE = 19'h00000;

    logic              clk = 1'b0;
    logic              aclr_n, s_valid, cu_busy;
    logic [7:0]        s_data;
    logic              s_ready, mem_we, mem_sel, start_proc_pulse, load_done, err_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data_out, cfg_mode;
    logic [15:0]       cfg_width, cfg_height, cfg_scale;

    image_stream_loader #(
        .ADDR_W    (19),
        .IN_BASE   (19'h00000),
        .MAX_PIXELS(262144)
    ) dut (
        .clk             (clk),
        .aclr_n          (aclr_n),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_data_out    (mem_data_out),
        .mem_sel         (mem_sel),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .cfg_scale       (cfg_scale),
        .cfg_mode        (cfg_mode),
        .start_proc_pulse(start_proc_pulse),
        .cu_busy         (cu_busy),
        .load_done       (load_done),
        .err_size        (err_size)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    wr_t expq[$];
    int  checks = 0, errors = 0;
    int  cyc = 0, acc_cyc = 0;
    int  nwrites = 0, first_we_cyc = 0, last_we_cyc = 0;
    int  first_addr = 0, first_data = 0, last_addr = 0, last_data = 0;
    int  nstarts = 0, start_cyc = 0;
    int  busy_len = 50;
    bit  cu_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix_val(input int k, input int w, input int pat);
        if (pat == 0) return 8'(((k / w) + 1) * 16 + (k % w));
        return 8'(k * 7 + 3);
    endfunction

    // Cycle numbering: a byte accepted at the edge that sets cyc=A is written in cycle A.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            nwrites++;
            if (nwrites == 1) begin
                first_we_cyc = cyc;
                first_addr   = int'(mem_addr);
                first_data   = int'(mem_data_out);
            end
            last_we_cyc = cyc;
            last_addr   = int'(mem_addr);
            last_data   = int'(mem_data_out);
            chk("we_owner", mem_sel, 1);
            chk("write_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("wr_addr", mem_addr, e.a);
                chk("wr_data", mem_data_out, e.d);
            end
        end
        chk("start_eq_done", start_proc_pulse, load_done);
        if (start_proc_pulse === 1'b1) begin
            nstarts++;
            start_cyc = cyc;
        end
        if (cu_busy === 1'b1) begin
            chk("busy_ready", s_ready, 0);
            chk("busy_sel", mem_sel, 0);
        end
    end

    // Control-unit stand-in: busy for busy_len cycles after each start pulse.
    initial begin
        cu_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (start_proc_pulse === 1'b1) begin
                cu_active = 1'b1;
                @(posedge clk); #1;
                cu_busy = 1'b1;
                repeat (busy_len) begin @(posedge clk); #1; end
                cu_busy = 1'b0;
                chk("ready_low_at_fall", s_ready, 0);
                @(posedge clk); #1;
                chk("ready_after_busy", s_ready, 1);
                cu_active = 1'b0;
            end
        end
    end

    task automatic push(input logic [7:0] b, input bit gap);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        if (s_ready !== 1'b1) chk("ready_timeout", s_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        s_valid = 1'b0;
        s_data  = 8'h00;
        if (gap) begin @(posedge clk); #1; end
    endtask

    task automatic load_frame(input logic [15:0] w, input logic [15:0] h, input logic [15:0] sc,
                              input logic [7:0] md, input bit gap, input int pat, input int npush);
        wr_t e;
        push(w[7:0], gap);  push(w[15:8], gap);
        push(h[7:0], gap);  push(h[15:8], gap);
        push(sc[7:0], gap); push(sc[15:8], gap);
        push(md, gap);
        for (int k = 0; k < npush; k++) begin
            e.a = IN_BASE + ADDR_W'(k);
            e.d = pix_val(k, int'(w), pat);
            expq.push_back(e);
            push(e.d, gap);
        end
    endtask

    task automatic wait_start(input int n0);
        int t = 0;
        while (nstarts == n0 && t < 50) begin @(posedge clk); #1; t++; end
        chk("start_seen", nstarts, n0 + 1);
        chk("start_latency", start_cyc - acc_cyc, 1);
        chk("flush_write_cycle", last_we_cyc, acc_cyc);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (cu_active && t < 300) begin @(posedge clk); #1; t++; end
        chk("cu_idle", cu_active, 0);
    endtask

    task automatic do_reset();
        aclr_n  = 1'b0;
        s_valid = 1'b0;
        @(posedge clk); #1;
        aclr_n = 1'b1;
        expq.delete();
    endtask

    // Called right after the mode byte is accepted: CHECK this cycle, ERROR from the next.
    task automatic check_error_entry();
        chk("check_cycle_err", err_size, 0);
        chk("check_cycle_ready", s_ready, 0);
        @(posedge clk); #1;
        chk("err_set", err_size, 1);
        chk("err_ready", s_ready, 0);
        chk("err_sel", mem_sel, 0);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("err_stuck_ready", s_ready, 0);
            chk("err_sticky", err_size, 1);
        end
        s_valid = 1'b0;
        chk("err_no_writes", nwrites, 0);
    endtask

    initial begin
        aclr_n  = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", s_ready, 1);
        chk("rst_sel", mem_sel, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data_out, 0);
        chk("rst_width", cfg_width, 0);
        chk("rst_height", cfg_height, 0);
        chk("rst_scale", cfg_scale, 0);
        chk("rst_mode", cfg_mode, 0);
        chk("rst_start", start_proc_pulse, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", err_size, 0);
        aclr_n = 1'b1;

        // Frame A: 8x4 back to back, CU busy 50 cycles afterwards.
        busy_len = 50;
        nwrites  = 0;
        load_frame(16'd8, 16'd4, 16'h0080, 8'h01, 1'b0, 0, 32);
        wait_start(0);
        chk("a_writes", nwrites, 32);
        chk("a_first_addr", first_addr, 0);
        chk("a_first_data", first_data, 16);
        chk("a_last_addr", last_addr, 31);
        chk("a_last_data", last_data, 71);
        chk("a_burst_len", last_we_cyc - first_we_cyc, 31);
        chk("a_cfg_width", cfg_width, 16'd8);
        chk("a_cfg_height", cfg_height, 16'd4);
        chk("a_cfg_scale", cfg_scale, 16'h0080);
        chk("a_cfg_mode", cfg_mode, 8'h01);
        chk("a_sel_after_start", mem_sel, 0);

        // Frame B: same image with s_valid toggling; header offered while CU is busy.
        nwrites = 0;
        load_frame(16'd8, 16'd4, 16'h0080, 8'h01, 1'b1, 0, 32);
        wait_start(1);
        chk("b_writes", nwrites, 32);
        chk("b_first_addr", first_addr, 0);
        chk("b_last_addr", last_addr, 31);
        chk("b_last_data", last_data, 71);
        chk("b_queue_empty", expq.size(), 0);
        wait_idle();

        // Oversize 1024x512 header: error, configuration from frame B retained.
        nwrites = 0;
        load_frame(16'd1024, 16'd512, 16'h0100, 8'h00, 1'b0, 0, 0);
        check_error_entry();
        chk("big_cfg_width", cfg_width, 16'd8);
        chk("big_cfg_height", cfg_height, 16'd4);
        chk("big_cfg_scale", cfg_scale, 16'h0080);
        chk("big_cfg_mode", cfg_mode, 8'h01);
        do_reset();
        chk("big_rst_err", err_size, 0);
        chk("big_rst_ready", s_ready, 1);
        chk("big_rst_cfg", cfg_width, 0);

        // Zero-width header.
        nwrites = 0;
        load_frame(16'd0, 16'd4, 16'h0080, 8'h01, 1'b0, 0, 0);
        check_error_entry();
        do_reset();
        chk("w0_rst_ready", s_ready, 1);
        chk("w0_rst_sel", mem_sel, 1);

        // Reset after 10 pixels abandons the frame.
        nwrites = 0;
        load_frame(16'd8, 16'd4, 16'h0080, 8'h01, 1'b0, 1, 10);
        aclr_n  = 1'b0;
        @(posedge clk); #1;
        chk("part_writes", nwrites, 10);
        chk("part_we", mem_we, 0);
        chk("part_width", cfg_width, 0);
        chk("part_height", cfg_height, 0);
        chk("part_scale", cfg_scale, 0);
        chk("part_mode", cfg_mode, 0);
        chk("part_ready", s_ready, 1);
        expq.delete();
        aclr_n = 1'b1;

        // Fresh 8x4 reload from address 0; CU busy for a single cycle.
        busy_len = 1;
        nwrites  = 0;
        load_frame(16'd8, 16'd4, 16'h0080, 8'h01, 1'b0, 1, 32);
        wait_start(2);
        chk("c_writes", nwrites, 32);
        chk("c_first_addr", first_addr, 0);
        chk("c_first_data", first_data, 3);
        chk("c_last_data", last_data, 220);
        chk("c_queue_empty", expq.size(), 0);
        wait_idle();
        chk("total_starts", nstarts, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
